// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: turns ioctl download strobes into EPROM write pulses, checks the image, gates CPU reset.
// Latency: ADDR_DL/DATA_DL/WR_DL one cycle after an IOCTL_WR rise is sampled; RUN SETTLE_CYCLES after a good load.
// Backpressure: none; the ioctl side must space strobe rises at least 2 cycles apart.
module rom_load_ctrl #(
  parameter int                ADDR_W         = 25,
  parameter logic [7:0]        ROM_INDEX      = 8'h00,
  parameter logic [ADDR_W-1:0] EXPECTED_BYTES = ADDR_W'(32'h2C000),
  parameter int                SETTLE_CYCLES  = 1024
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              IOCTL_DOWNLOAD,
  input  logic [7:0]        IOCTL_INDEX,
  input  logic              IOCTL_WR,
  input  logic [ADDR_W-1:0] IOCTL_ADDR,
  input  logic [7:0]        IOCTL_DOUT,
  output logic [ADDR_W-1:0] ADDR_DL,
  output logic [7:0]        DATA_DL,
  output logic              WR_DL,
  output logic              CPU_RESETn,
  output logic              LOAD_BUSY,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W-1:0] BYTE_COUNT
);

  localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             wr_q;
  logic             dl_q;
  logic [CNT_W-1:0] settle_cnt;

  logic idx_ok;
  logic start;
  logic accept;
  logic image_ok;
  logic load_eval;
  logic load_fail;
  logic enter_load;

  // A download starts only on a rising IOCTL_DOWNLOAD edge, so one already in
  // progress when reset releases is ignored (dl_q resets high for that reason).
  // dl_q stays high through the cycle IOCTL_DOWNLOAD is first seen low, which
  // lets a strobe landing on that same cycle still be accepted; the completion
  // check then runs one cycle later against the updated count.
  assign idx_ok     = (IOCTL_INDEX == ROM_INDEX);
  assign start      = IOCTL_DOWNLOAD && idx_ok && !dl_q;
  assign accept     = (state == S_LOAD) && dl_q && idx_ok && IOCTL_WR && !wr_q;
  assign image_ok   = !LOAD_ERR && (BYTE_COUNT == EXPECTED_BYTES);
  assign load_eval  = (state == S_LOAD) && !dl_q;
  assign load_fail  = load_eval && !image_ok;
  assign enter_load = (state != S_LOAD) && (state_nxt == S_LOAD);

  assign CPU_RESETn = (state == S_RUN);
  assign LOAD_DONE  = (state == S_RUN);
  assign LOAD_BUSY  = (state == S_LOAD);

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_eval) state_nxt = image_ok ? S_SETTLE : S_FAIL;
      end
      S_SETTLE: begin
        if (start)                            state_nxt = S_LOAD;
        else if (settle_cnt == SETTLE_LAST)   state_nxt = S_RUN;
      end
      S_RUN, S_FAIL: begin
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Previous-cycle copies of the strobe and download level for edge detection.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_q <= 1'b0;
      dl_q <= 1'b1;
    end else begin
      wr_q <= IOCTL_WR;
      dl_q <= IOCTL_DOWNLOAD;
    end
  end

  // Settle counter runs only while in SETTLE.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      settle_cnt <= '0;
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ADDR_DL <= '0;
      DATA_DL <= '0;
      WR_DL   <= 1'b0;
    end else begin
      WR_DL <= accept;
      if (accept) begin
        ADDR_DL <= IOCTL_ADDR;
        DATA_DL <= IOCTL_DOUT;
      end
    end
  end

  // Byte counter and sticky error; both restart when a new load begins.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      BYTE_COUNT <= '0;
      LOAD_ERR   <= 1'b0;
    end else if (enter_load) begin
      BYTE_COUNT <= '0;
      LOAD_ERR   <= 1'b0;
    end else begin
      if (accept) begin
        if (BYTE_COUNT != {ADDR_W{1'b1}}) BYTE_COUNT <= BYTE_COUNT + ADDR_W'(1);
        if (IOCTL_ADDR != BYTE_COUNT)      LOAD_ERR   <= 1'b1;
      end
      if (load_fail) LOAD_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: directed bench for rom_load_ctrl with a reduced image size.
// Image is 0x200 bytes, settle interval 16 cycles; data byte is a function of address.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_rom_load_ctrl;

  localparam int                ADDR_W    = 25;
  localparam logic [ADDR_W-1:0] EXP_BYTES = 25'h200;
  localparam int                SETTLE    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] addr_dl;
  logic [7:0]        data_dl;
  logic              wr_dl;
  logic              cpu_resetn;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int bad_wr   = 0;
  bit pat_mode = 1'b1;
  logic wr_prev = 1'b0;
  int base;

  rom_load_ctrl #(
    .ADDR_W        (ADDR_W),
    .ROM_INDEX     (8'h00),
    .EXPECTED_BYTES(EXP_BYTES),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .CLK           (clk),
    .RESETn        (rst_n),
    .IOCTL_DOWNLOAD(ioctl_download),
    .IOCTL_INDEX   (ioctl_index),
    .IOCTL_WR      (ioctl_wr),
    .IOCTL_ADDR    (ioctl_addr),
    .IOCTL_DOUT    (ioctl_dout),
    .ADDR_DL       (addr_dl),
    .DATA_DL       (data_dl),
    .WR_DL         (wr_dl),
    .CPU_RESETn    (cpu_resetn),
    .LOAD_BUSY     (load_busy),
    .LOAD_DONE     (load_done),
    .LOAD_ERR      (load_err),
    .BYTE_COUNT    (byte_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Write monitor: counts pulses, flags back-to-back pulses and data not matching the address pattern.
  always @(negedge clk) begin
    if (wr_dl) begin
      wr_cnt++;
      if (pat_mode && (data_dl != pat(addr_dl))) bad_wr++;
      if (wr_prev) bad_wr++;
    end
    wr_prev = wr_dl;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
  endtask

  // Sends n bytes starting at index first; with skip, address 0x100 is jumped over.
  task automatic send_bytes(input int first, input int n, input bit skip);
    for (int i = first; i < first + n; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(i);
      if (skip && (i >= 'h100)) a = ADDR_W'(i + 1);
      strobe(a, pat(a), 1);
    end
  endtask

  // Full sequential load followed by the settle window, ending in RUN.
  task automatic good_load();
    int b;
    b = wr_cnt;
    start_dl(8'h00);
    @(negedge clk);
    check("load_busy", load_busy, 1'b1);
    check("load_cpu_rst", cpu_resetn, 1'b0);
    send_bytes(0, int'(EXP_BYTES), 1'b0);
    check("load_count", byte_count, EXP_BYTES);
    check("load_err_clear", load_err, 1'b0);
    end_dl();
    @(negedge clk);
    check("busy_after_fall", load_busy, 1'b1);
    @(negedge clk);
    check("settle_busy", load_busy, 1'b0);
    check("settle_cpu_rst", cpu_resetn, 1'b0);
    repeat (SETTLE - 1) @(negedge clk);
    check("settle_last_cpu", cpu_resetn, 1'b0);
    check("settle_last_done", load_done, 1'b0);
    @(negedge clk);
    check("run_cpu", cpu_resetn, 1'b1);
    check("run_done", load_done, 1'b1);
    check("run_err", load_err, 1'b0);
    check("load_wr_pulses", wr_cnt - b, EXP_BYTES);
    check("load_wr_data", bad_wr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", addr_dl, 0);
    check("rst_data", data_dl, 0);
    check("rst_wr", wr_dl, 0);
    check("rst_cpu", cpu_resetn, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_count", byte_count, 0);
    rst_n = 1'b1;

    // Good image reaches RUN.
    good_load();

    // Foreign index while in RUN: ignored entirely.
    base = wr_cnt;
    start_dl(8'h01);
    send_bytes(0, 4, 1'b0);
    end_dl();
    repeat (3) @(negedge clk);
    check("idx1_no_writes", wr_cnt - base, 0);
    check("idx1_done", load_done, 1'b1);
    check("idx1_cpu", cpu_resetn, 1'b1);
    check("idx1_count", byte_count, EXP_BYTES);

    // New download from RUN, then one strobe held 4 cycles.
    start_dl(8'h00);
    @(negedge clk);
    check("restart_cpu", cpu_resetn, 1'b0);
    check("restart_count", byte_count, 0);
    check("restart_busy", load_busy, 1'b1);
    pat_mode = 1'b0;
    base = wr_cnt;
    @(negedge clk);
    ioctl_addr = '0;
    ioctl_dout = 8'h55;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    check("hold_wr", wr_dl, 1'b1);
    check("hold_addr", addr_dl, 0);
    check("hold_data", data_dl, 8'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_no_repulse", wr_dl, 1'b0);
    end
    ioctl_wr = 1'b0;
    @(negedge clk);
    check("hold_pulses", wr_cnt - base, 1);
    check("hold_count", byte_count, 1);
    check("hold_data_kept", data_dl, 8'h55);
    pat_mode = 1'b1;
    end_dl();
    repeat (2) @(negedge clk);
    check("short1_busy", load_busy, 1'b0);
    check("short1_err", load_err, 1'b1);
    check("short1_cpu", cpu_resetn, 1'b0);

    // Address 0x100 skipped.
    start_dl(8'h00);
    send_bytes(0, 'h100, 1'b1);
    check("skip_err_before", load_err, 1'b0);
    send_bytes('h100, 'h100, 1'b1);
    check("skip_err_after", load_err, 1'b1);
    end_dl();
    repeat (2) @(negedge clk);
    check("skip_fail_busy", load_busy, 1'b0);
    check("skip_fail_done", load_done, 1'b0);
    check("skip_fail_cpu", cpu_resetn, 1'b0);
    check("skip_fail_err", load_err, 1'b1);
    check("skip_count", byte_count, EXP_BYTES);

    // Recovery with a good image.
    good_load();

    // Image one byte short.
    start_dl(8'h00);
    send_bytes(0, int'(EXP_BYTES) - 1, 1'b0);
    end_dl();
    repeat (2) @(negedge clk);
    check("short_err", load_err, 1'b1);
    check("short_count", byte_count, EXP_BYTES - 1);
    check("short_cpu", cpu_resetn, 1'b0);
    check("short_busy", load_busy, 1'b0);

    // Last strobe rises in the same cycle the download falls.
    start_dl(8'h00);
    send_bytes(0, int'(EXP_BYTES) - 1, 1'b0);
    @(negedge clk);
    ioctl_addr     = EXP_BYTES - 1;
    ioctl_dout     = pat(EXP_BYTES - 1);
    ioctl_wr       = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk);
    check("edge_wr", wr_dl, 1'b1);
    check("edge_count", byte_count, EXP_BYTES);
    check("edge_busy", load_busy, 1'b1);
    ioctl_wr = 1'b0;
    @(negedge clk);
    check("edge_settle_busy", load_busy, 1'b0);
    check("edge_err", load_err, 1'b0);
    repeat (SETTLE) @(negedge clk);
    check("edge_run", load_done, 1'b1);

    // Reset asserted partway through a load.
    start_dl(8'h00);
    send_bytes(0, 'h80, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", addr_dl, 0);
    check("mid_rst_data", data_dl, 0);
    check("mid_rst_count", byte_count, 0);
    check("mid_rst_busy", load_busy, 0);
    check("mid_rst_cpu", cpu_resetn, 0);
    check("mid_rst_done", load_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    send_bytes('h80, 16, 1'b0);
    end_dl();
    repeat (2) @(negedge clk);
    check("mid_rst_no_writes", wr_cnt - base, 0);
    check("mid_rst_idle_busy", load_busy, 1'b0);
    check("mid_rst_idle_count", byte_count, 0);
    check("mid_rst_idle_cpu", cpu_resetn, 1'b0);

    // A fresh download after reset loads normally.
    good_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
